// File: rtl/axis_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_tx
// Description : Frames a valid/ready sample stream into tlast-terminated
//               AXI-stream bursts through a single output register slice.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_tx #(
    parameter int DATA_W = 22,
    parameter int LEN_W  = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  frames_sent,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] output_tdata,
    output logic              output_tvalid,
    input  logic              output_tready,
    output logic              output_tlast
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_issued;
    logic               w_load;
    logic               w_last;

    // Slice may take a new sample when empty or emptying this cycle.
    assign s_ready = (r_state == S_ACTIVE) && (r_issued < r_len) &&
                     (!output_tvalid || output_tready);
    assign w_load  = s_valid && s_ready;
    assign w_last  = (r_issued == (r_len - 1'b1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_issued      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            frames_sent   <= '0;
            output_tdata  <= '0;
            output_tvalid <= 1'b0;
            output_tlast  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && (frame_len != '0)) begin
                        r_len    <= frame_len;
                        r_issued <= '0;
                        busy     <= 1'b1;
                        r_state  <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_load) begin
                        output_tdata  <= s_data;
                        output_tvalid <= 1'b1;
                        output_tlast  <= w_last;
                        r_issued      <= r_issued + 1'b1;
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end
                    end else if (output_tready) begin
                        output_tvalid <= 1'b0;
                        output_tlast  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (output_tvalid && output_tready) begin
                        output_tvalid <= 1'b0;
                        output_tlast  <= 1'b0;
                        done          <= 1'b1;
                        frames_sent   <= frames_sent + 1'b1;
                        busy          <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
